// File: rtl/mem_arbiter_if.sv
// Shared handshake bundle between the CPU requesters, the arbiter and the
// memory controller port.
interface mem_arbiter_if;
  // fetch requester
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic        instr_valid;
  // data (load/store) requester
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_valid;
  // memory controller port
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic        busy;

  // arbiter view: drives responses and the controller request
  modport master (
    input  instr_req, instr_addr, data_req, data_wr, data_addr, data_wdata,
           bus_rdata, bus_ack,
    output instr_rdata, instr_valid, data_rdata, data_valid,
           bus_req, bus_wr, bus_addr, bus_wdata, bus_err, busy
  );

  // environment view: requesters plus memory controller
  modport slave (
    output instr_req, instr_addr, data_req, data_wr, data_addr, data_wdata,
           bus_rdata, bus_ack,
    input  instr_rdata, instr_valid, data_rdata, data_valid,
           bus_req, bus_wr, bus_addr, bus_wdata, bus_err, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory-controller port between instruction fetch and
// data load/store. Data has priority; a fetch that has waited STARVE_MAX
// cycles wins the next contested arbitration. Transactions without an ack
// for TIMEOUT busy cycles complete with ERR_DATA and a bus_err pulse.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.master arb
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX    = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic          owner_instr;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;
  logic          elig_i;
  logic          elig_d;
  logic          grant_i;
  logic          grant_d;

  // Eligibility masks the requester whose valid is high this cycle, since it
  // is about to drop req; then data-first priority with starvation override.
  always_comb begin
    elig_i  = arb.instr_req & ~arb.instr_valid;
    elig_d  = arb.data_req  & ~arb.data_valid;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == S_IDLE) begin
      grant_i = elig_i & (~elig_d | (starve_cnt >= SMAX));
      grant_d = elig_d & ~grant_i;
    end
  end

  // Transaction FSM: grant/latch, wait for ack or timeout, then respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      owner_instr     <= 1'b0;
      to_cnt          <= '0;
      arb.instr_rdata <= '0;
      arb.instr_valid <= 1'b0;
      arb.data_rdata  <= '0;
      arb.data_valid  <= 1'b0;
      arb.bus_req     <= 1'b0;
      arb.bus_wr      <= 1'b0;
      arb.bus_addr    <= '0;
      arb.bus_wdata   <= '0;
      arb.bus_err     <= 1'b0;
      arb.busy        <= 1'b0;
    end else begin
      arb.instr_valid <= 1'b0;
      arb.data_valid  <= 1'b0;
      arb.bus_err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_i) begin
            state        <= S_BUSY_I;
            owner_instr  <= 1'b1;
            arb.bus_addr <= arb.instr_addr;
            arb.bus_wr   <= 1'b0;
            arb.bus_req  <= 1'b1;
            arb.busy     <= 1'b1;
            to_cnt       <= '0;
          end else if (grant_d) begin
            state         <= S_BUSY_D;
            owner_instr   <= 1'b0;
            arb.bus_addr  <= arb.data_addr;
            arb.bus_wr    <= arb.data_wr;
            arb.bus_wdata <= arb.data_wdata;
            arb.bus_req   <= 1'b1;
            arb.busy      <= 1'b1;
            to_cnt        <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          // ack is checked first so an ack on the final timeout cycle wins
          if (arb.bus_ack) begin
            if (state == S_BUSY_I)  arb.instr_rdata <= arb.bus_rdata;
            else if (!arb.bus_wr)   arb.data_rdata  <= arb.bus_rdata;
            arb.bus_req <= 1'b0;
            state       <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            if (state == S_BUSY_I)  arb.instr_rdata <= ERR_DATA;
            else if (!arb.bus_wr)   arb.data_rdata  <= ERR_DATA;
            arb.bus_err <= 1'b1;
            arb.bus_req <= 1'b0;
            state       <= S_RESP;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_RESP: begin
          if (owner_instr) arb.instr_valid <= 1'b1;
          else             arb.data_valid  <= 1'b1;
          arb.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Starvation counter: counts cycles a fetch waits while it does not own
  // the bus; saturates, and clears when fetch is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (arb.instr_req && (state != S_BUSY_I) &&
                 !((state == S_RESP) && owner_instr) && (starve_cnt < SMAX)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule
